// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
// Unsigned shift-and-add multiplier that borrows an external shared ALU.
// Each multiplier bit takes three ALU passes: conditional add of the
// multiplicand into the accumulator, multiplicand shift left, and multiplier
// shift right. The result is the low 32 bits of op_a*op_b. Arithmetic wraps
// modulo 2^32.
//
// Optional feature (macro EARLY_TERM_EN): when defined, the sequence finishes
// as soon as the shifted multiplier becomes zero (alu_z). Result values are
// the same in both builds. Only the latency differs.
//
// Parameters:
//   NUM_BITS  number of multiplier bits processed (1..32)
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     multiply request, sampled only while idle
//   op_a      multiplicand, captured on the start edge
//   op_b      multiplier, captured on the start edge
//   busy      high in every state except IDLE
//   done      one-cycle pulse while result becomes valid
//   result    registered product, held until the next done
//   alu_a     shared ALU operand A
//   alu_b     shared ALU operand B
//   alu_op    shared ALU opcode
//   alu_out   shared ALU result
//   alu_z     shared ALU zero flag
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_z
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 4;
    localparam int unsigned CW  = 6;

    localparam logic [OPW-1:0] ALU_ADD    = 4'b0000;
    localparam logic [OPW-1:0] ALU_SHL    = 4'b0110;
    localparam logic [OPW-1:0] ALU_SHR    = 4'b0111;
    localparam logic [OPW-1:0] ALU_PASS_A = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DW-1:0]   acc;
    logic [DW-1:0]   acc_nxt;
    logic [DW-1:0]   mcand;
    logic [DW-1:0]   mcand_nxt;
    logic [DW-1:0]   mplier;
    logic [DW-1:0]   mplier_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic [DW-1:0]   result_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic [DW-1:0]   alu_a_nxt;
    logic [DW-1:0]   alu_b_nxt;
    logic [OPW-1:0]  alu_op_nxt;
    logic            last_iter;
    logic            finish;

    // Final iteration reached when the incremented count equals NUM_BITS.
    assign last_iter = ((cnt + CW'(1)) == CW'(NUM_BITS));

`ifdef EARLY_TERM_EN
    // Stop early once the multiplier has no set bits left.
    assign finish = last_iter | alu_z;
`else
    logic alu_z_unused;
    assign alu_z_unused = alu_z;
    assign finish       = last_iter;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath updates and registered-output preparation.
    // The ALU drive is computed for the state being entered so that the
    // registered alu_* outputs are valid for the whole of that state.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        result_nxt = result;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        alu_a_nxt  = '0;
        alu_b_nxt  = '0;
        alu_op_nxt = ALU_PASS_A;

        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nxt    = '0;
                    mcand_nxt  = op_a;
                    mplier_nxt = op_b;
                    cnt_nxt    = '0;
                    state_nxt  = S_ADD;
                end
            end
            S_ADD: begin
                acc_nxt   = alu_out;
                state_nxt = S_SHL;
            end
            S_SHL: begin
                mcand_nxt = alu_out;
                state_nxt = S_SHR;
            end
            S_SHR: begin
                mplier_nxt = alu_out;
                cnt_nxt    = cnt + CW'(1);
                state_nxt  = finish ? S_DONE : S_ADD;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);

        // The accumulator is final on entry to DONE; publish it then.
        if (state_nxt == S_DONE) begin
            result_nxt = acc_nxt;
        end

        case (state_nxt)
            S_ADD: begin
                alu_a_nxt  = acc_nxt;
                alu_b_nxt  = mcand_nxt;
                alu_op_nxt = mplier_nxt[0] ? ALU_ADD : ALU_PASS_A;
            end
            S_SHL: begin
                alu_a_nxt  = mcand_nxt;
                alu_b_nxt  = DW'(1);
                alu_op_nxt = ALU_SHL;
            end
            S_SHR: begin
                alu_a_nxt  = mplier_nxt;
                alu_b_nxt  = DW'(1);
                alu_op_nxt = ALU_SHR;
            end
            default: begin
                alu_a_nxt  = '0;
                alu_b_nxt  = '0;
                alu_op_nxt = ALU_PASS_A;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= ALU_PASS_A;
        end else begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            alu_a  <= alu_a_nxt;
            alu_b  <= alu_b_nxt;
            alu_op <= alu_op_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Bench for alu_mul_sequencer. It provides a behavioural shared ALU and a
// transaction-level model of the expected product, latency and busy/done
// timing. It also makes hand-computed literal checks on the directed vectors.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_z;

`ifdef EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int n_done     = 0;
    int cyc        = 0;
    bit chk_en     = 1'b0;

    // Model state: cycles left in the current operation (0 = idle).
    int          m_rem  = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res  = '0;

    alu_mul_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .alu_z   (alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU behaviour.
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b1010: alu_out = alu_a;
            4'b0110: alu_out = alu_a << alu_b;
            4'b0111: alu_out = alu_a >> alu_b;
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_z = (alu_out == 32'd0);

    function automatic int bit_len(input logic [31:0] b);
        int n = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic int exp_iters(input logic [31:0] b);
        return EARLY ? bit_len(b) : 32;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model of the sequencer timing and product.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem <= 0;
            m_res <= '0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem  <= 3 * exp_iters(op_b) + 1;
                m_pend <= op_a * op_b;
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) m_res <= m_pend;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   32'(busy),   32'(m_rem != 0));
            check("done",   32'(done),   32'(m_rem == 1));
            check("result", result,      m_res);
            if (m_rem <= 1) begin
                check("alu_a_idle",  alu_a,         32'd0);
                check("alu_b_idle",  alu_b,         32'd0);
                check("alu_op_idle", 32'(alu_op),   32'hA);
            end
            if (done) n_done++;
        end
    end

    task automatic wait_done(input string name, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        check({name, "_timeout"}, 32'(got), 32'd1);
    endtask

    // One multiply; returns the cycle index of the done pulse (1 = first
    // cycle after the capture edge). Pokes start and operands while busy.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, output int lat);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        lat   = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
            if (i == 1) start = 1'b1;
            if (i == 2) start = 1'b0;
        end
        start = 1'b0;
        check({name, "_timeout"}, 32'(got),  32'd1);
        check({name, "_latency"}, 32'(lat),  32'(3 * exp_iters(b) + 1));
        check({name, "_result"},  result,    exp_res);
        @(posedge clk);
        #1;
    endtask

    int lat;
    int d0;
    int t1;
    int t2;

    initial begin
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", result,      32'd0);
        check("rst_alu_op", 32'(alu_op), 32'hA);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic product and full-length latency.
        run_op("mul_6x7", 32'd6, 32'd7, 32'd42, lat);
        if (!EARLY) check("lat_97", 32'(lat), 32'd97);

        // Wrap-around cases.
        run_op("wrap_ffx2",  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, lat);
        run_op("wrap_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         lat);
        run_op("msb_x3",     32'h8000_0000, 32'd3,         32'h8000_0000, lat);
        run_op("shift16",    32'h0001_2345, 32'h0001_0000, 32'h2345_0000, lat);
        run_op("zero_a",     32'd0,         32'h0000_1234, 32'd0,         lat);

        // Short multipliers: early termination latency when enabled.
        run_op("mul_5x3", 32'd5, 32'd3, 32'd15, lat);
        if (EARLY) check("lat_5x3", 32'(lat), 32'd7);
        run_op("mul_9x0", 32'd9, 32'd0, 32'd0, lat);
        if (EARLY) check("lat_9x0", 32'(lat), 32'd4);

        // Start held high: two back-to-back operations, none captured in DONE.
        d0 = n_done;
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd4;
        wait_done("b2b_first", lat);
        t1 = cyc;
        check("b2b_first_result", result, 32'd12);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_second", lat);
        t2 = cyc;
        check("b2b_second_result", result, 32'd12);
        check("b2b_gap", 32'(t2 - t1), 32'(3 * exp_iters(32'd4) + 2));
        repeat (5) @(negedge clk);
        check("b2b_done_count", 32'(n_done - d0), 32'd2);

        // Reset in the middle of a full-length multiply.
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = 32'd9;
        op_b  = 32'h8000_0000;
        @(posedge clk);
        #1 start = 1'b0;
        d0 = n_done;
        repeat (40) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_result", result,    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (110) @(negedge clk);
        check("abort_no_done",  32'(n_done - d0), 32'd0);
        check("abort_result_hold", result, 32'd0);

        run_op("mul_2x2", 32'd2, 32'd2, 32'd4, lat);
        repeat (3) @(negedge clk);
        check("hold_result", result, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
